// File: rtl/sync_fifo_flex_if.sv
// Handshake and status bundle for sync_fifo_flex.
// The FIFO attaches through the slave modport and the user logic through the master modport.
interface sync_fifo_flex_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] wdata;
    logic                  winc;
    logic                  wfull;
    logic                  walmost_full;
    logic                  rinc;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rempty;
    logic                  ralmost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  clr_err;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wdata, winc, rinc, clr_err,
        input  wfull, walmost_full, rdata, rempty, ralmost_empty, count, overflow, underflow
    );

    modport slave (
        input  wdata, winc, rinc, clr_err,
        output wfull, walmost_full, rdata, rempty, ralmost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flex.sv
// Parametrised single-clock FIFO with an optional first-word-fall-through read,
// almost-full/almost-empty thresholds, an occupancy count and sticky error flags.
module sync_fifo_flex #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = 2**ADDR_WIDTH - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input logic              clk,
    input logic              rst,
    sync_fifo_flex_if.slave  bus
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] AFULL_LV  = (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AEMPTY_LV = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

    generate
        if (ADDR_WIDTH < 1 || AEMPTY_THRESH >= AFULL_THRESH || AFULL_THRESH > DEPTH) begin : g_bad_params
            $fatal(1, "sync_fifo_flex: illegal ADDR_WIDTH/AFULL_THRESH/AEMPTY_THRESH combination");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wptr;
    logic [ADDR_WIDTH:0]   rptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  full;
    logic                  empty;
    logic                  wr_en;
    logic                  rd_en;
    logic                  overflow_q;
    logic                  underflow_q;

    // Extra pointer MSB tells full from empty when the low address bits match.
    assign count = wptr - rptr;
    assign full  = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) &&
                   (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);
    assign empty = (wptr == rptr);
    assign wr_en = bus.winc && !full && !rst;
    assign rd_en = bus.rinc && !empty;

    assign bus.count         = count;
    assign bus.wfull         = full;
    assign bus.rempty        = empty;
    assign bus.walmost_full  = (count >= AFULL_LV);
    assign bus.ralmost_empty = (count <= AEMPTY_LV);
    assign bus.overflow      = overflow_q;
    assign bus.underflow     = underflow_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr[ADDR_WIDTH-1:0]] <= bus.wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_en) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    // A new error event in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.winc && full) begin
                overflow_q <= 1'b1;
            end else if (bus.clr_err) begin
                overflow_q <= 1'b0;
            end
            if (bus.rinc && empty) begin
                underflow_q <= 1'b1;
            end else if (bus.clr_err) begin
                underflow_q <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.rdata = mem[rptr[ADDR_WIDTH-1:0]];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] rdata_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rdata_q <= '0;
                end else if (rd_en) begin
                    rdata_q <= mem[rptr[ADDR_WIDTH-1:0]];
                end
            end

            assign bus.rdata = rdata_q;
        end
    endgenerate
endmodule

// File: tb/tb_sync_fifo_flex.sv
// Directed bench for sync_fifo_flex: one standard-mode and one FWFT instance (DEPTH=16)
// sharing clk/rst, each driven through its own interface instance.
module tb_sync_fifo_flex;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [7:0] model_q[$];
    logic [7:0] exp_data;

    sync_fifo_flex_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) s_if ();
    sync_fifo_flex_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) f_if ();

    sync_fifo_flex #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(0)) dut_std (
        .clk (clk),
        .rst (rst),
        .bus (s_if)
    );

    sync_fifo_flex #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1)) dut_fwft (
        .clk (clk),
        .rst (rst),
        .bus (f_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic winc, input logic rinc, input logic clr_err, input logic [7:0] wdata);
        s_if.winc    = winc;
        s_if.rinc    = rinc;
        s_if.clr_err = clr_err;
        s_if.wdata   = wdata;
        tick();
        s_if.winc    = 1'b0;
        s_if.rinc    = 1'b0;
        s_if.clr_err = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        s_if.wdata = '0; s_if.winc = 1'b0; s_if.rinc = 1'b0; s_if.clr_err = 1'b0;
        f_if.wdata = '0; f_if.winc = 1'b0; f_if.rinc = 1'b0; f_if.clr_err = 1'b0;
        #3;
        check_output("rst_count",     32'(s_if.count), 0);
        check_output("rst_rempty",    32'(s_if.rempty), 1);
        check_output("rst_wfull",     32'(s_if.wfull), 0);
        check_output("rst_raempty",   32'(s_if.ralmost_empty), 1);
        check_output("rst_wafull",    32'(s_if.walmost_full), 0);
        check_output("rst_overflow",  32'(s_if.overflow), 0);
        check_output("rst_underflow", 32'(s_if.underflow), 0);
        check_output("rst_rdata",     32'(s_if.rdata), 0);
        @(negedge clk);
        rst = 1'b0;

        // Fill with 0x00..0x0F.
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(1'b1, 1'b0, 1'b0, 8'(i));
            check_output($sformatf("fill_count_%0d", i), 32'(s_if.count), 32'(i + 1));
            check_output($sformatf("fill_wafull_%0d", i), 32'(s_if.walmost_full), 32'((i + 1) >= 14));
            check_output($sformatf("fill_wfull_%0d", i), 32'(s_if.wfull), 32'(i == 15));
            check_output($sformatf("fill_rempty_%0d", i), 32'(s_if.rempty), 0);
        end
        apply_stimulus(1'b1, 1'b0, 1'b0, 8'hFF);
        check_output("ovf_set",   32'(s_if.overflow), 1);
        check_output("ovf_count", 32'(s_if.count), 16);

        // Drain in order; data appears one edge after its rinc.
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00);
            check_output($sformatf("drain_rdata_%0d", i), 32'(s_if.rdata), 32'(i));
            check_output($sformatf("drain_count_%0d", i), 32'(s_if.count), 32'(15 - i));
            check_output($sformatf("drain_raempty_%0d", i), 32'(s_if.ralmost_empty), 32'((15 - i) <= 2));
            check_output($sformatf("drain_rempty_%0d", i), 32'(s_if.rempty), 32'(i == 15));
        end
        apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00);
        check_output("udf_set",   32'(s_if.underflow), 1);
        check_output("udf_rdata", 32'(s_if.rdata), 32'h0F);
        check_output("udf_count", 32'(s_if.count), 0);

        apply_stimulus(1'b0, 1'b0, 1'b1, 8'h00);
        check_output("clr_ovf", 32'(s_if.overflow), 0);
        check_output("clr_udf", 32'(s_if.underflow), 0);

        // Set condition wins over clr_err in the same cycle.
        apply_stimulus(1'b0, 1'b1, 1'b1, 8'h00);
        check_output("setwin_udf", 32'(s_if.underflow), 1);
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
            model_q.push_back(8'(8'h40 + i));
        end
        apply_stimulus(1'b1, 1'b0, 1'b1, 8'hEE);
        check_output("setwin_ovf",     32'(s_if.overflow), 1);
        check_output("setwin_udf_clr", 32'(s_if.underflow), 0);
        check_output("setwin_count",   32'(s_if.count), 16);
        apply_stimulus(1'b0, 1'b0, 1'b1, 8'h00);
        check_output("clr2_ovf", 32'(s_if.overflow), 0);
        check_output("clr2_udf", 32'(s_if.underflow), 0);

        // Drain to 8, then hold occupancy with simultaneous traffic across pointer wraps.
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00);
            exp_data = model_q.pop_front();
            check_output($sformatf("half_rdata_%0d", i), 32'(s_if.rdata), 32'(exp_data));
        end
        check_output("half_count", 32'(s_if.count), 8);
        for (int k = 0; k < 40; k++) begin
            apply_stimulus(1'b1, 1'b1, 1'b0, 8'(8'h80 + k));
            model_q.push_back(8'(8'h80 + k));
            exp_data = model_q.pop_front();
            check_output($sformatf("wrap_rdata_%0d", k), 32'(s_if.rdata), 32'(exp_data));
            check_output($sformatf("wrap_count_%0d", k), 32'(s_if.count), 8);
            check_output($sformatf("wrap_flags_%0d", k),
                         32'({s_if.wfull, s_if.rempty, s_if.walmost_full, s_if.ralmost_empty}), 0);
        end

        // Reduce to 5 entries and reset between edges.
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00);
            exp_data = model_q.pop_front();
            check_output($sformatf("pre_rst_rdata_%0d", i), 32'(s_if.rdata), 32'(exp_data));
        end
        check_output("pre_rst_count", 32'(s_if.count), 5);
        #1;
        rst = 1'b1;
        #1;
        check_output("async_rst_count",    32'(s_if.count), 0);
        check_output("async_rst_rempty",   32'(s_if.rempty), 1);
        check_output("async_rst_overflow", 32'(s_if.overflow), 0);
        check_output("async_rst_rdata",    32'(s_if.rdata), 0);
        @(negedge clk);
        rst = 1'b0;
        apply_stimulus(1'b1, 1'b0, 1'b0, 8'h11);
        apply_stimulus(1'b1, 1'b0, 1'b0, 8'h22);
        check_output("restart_count", 32'(s_if.count), 2);
        apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00);
        check_output("restart_rdata0", 32'(s_if.rdata), 32'h11);
        apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00);
        check_output("restart_rdata1", 32'(s_if.rdata), 32'h22);
        check_output("restart_rempty", 32'(s_if.rempty), 1);

        // FWFT instance: head visible without a read request.
        check_output("fwft_init_rempty", 32'(f_if.rempty), 1);
        f_if.wdata = 8'hA5;
        f_if.winc  = 1'b1;
        tick();
        f_if.winc  = 1'b0;
        check_output("fwft_rempty",  32'(f_if.rempty), 0);
        check_output("fwft_rdata",   32'(f_if.rdata), 32'hA5);
        tick();
        check_output("fwft_hold",    32'(f_if.rdata), 32'hA5);
        f_if.rinc = 1'b1;
        tick();
        f_if.rinc = 1'b0;
        check_output("fwft_pop_rempty", 32'(f_if.rempty), 1);
        check_output("fwft_pop_count",  32'(f_if.count), 0);
        f_if.winc  = 1'b1;
        f_if.wdata = 8'h3C;
        tick();
        f_if.wdata = 8'h5A;
        tick();
        f_if.winc  = 1'b0;
        check_output("fwft_head0", 32'(f_if.rdata), 32'h3C);
        f_if.rinc = 1'b1;
        tick();
        f_if.rinc = 1'b0;
        check_output("fwft_head1", 32'(f_if.rdata), 32'h5A);
        check_output("fwft_count1", 32'(f_if.count), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
